// File: rtl/ula_sequenciador_deslocamento.sv
// Sequential command master for the 4-bit ALU: accepts one request, drives the ALU from
// registered operands, iterates single-bit shifts n times, and returns the result.
module ula_sequenciador_deslocamento (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_A,
  input  logic [3:0] req_B,
  input  logic [2:0] req_op,
  input  logic [2:0] req_n,
  output logic [3:0] ula_A,
  output logic [3:0] ula_B,
  output logic [2:0] ula_seletor,
  input  logic [3:0] ula_resultado,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_resultado
);

  typedef enum logic [1:0] {
    StOcioso,
    StExecuta,
    StResponde
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] acc_q, acc_d;
  logic [3:0] b_q, b_d;
  logic [2:0] op_q, op_d;
  logic [2:0] rest_q, rest_d;
  logic       req_is_shift;

  // Ops 110 (LSL) and 111 (LSR) are the only shifts.
  assign req_is_shift = (req_op[2:1] == 2'b11);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StOcioso;
      acc_q   <= 4'b0000;
      b_q     <= 4'b0000;
      op_q    <= 3'b000;
      rest_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      op_q    <= op_d;
      rest_q  <= rest_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    b_d     = b_q;
    op_d    = op_q;
    rest_d  = rest_q;
    unique case (state_q)
      StOcioso: begin
        if (req_valid) begin
          acc_d  = req_A;
          b_d    = req_B;
          op_d   = req_op;
          rest_d = req_is_shift ? req_n : 3'd1;
          // A zero-length shift needs no ALU pass: the result is A itself.
          state_d = (req_is_shift && (req_n == 3'd0)) ? StResponde : StExecuta;
        end
      end
      StExecuta: begin
        acc_d  = ula_resultado;
        rest_d = rest_q - 3'd1;
        if (rest_q == 3'd1) begin
          state_d = StResponde;
        end
      end
      StResponde: begin
        if (rsp_ready) begin
          state_d = StOcioso;
        end
      end
      default: begin
        state_d = StOcioso;
      end
    endcase
  end

  assign req_ready     = (state_q == StOcioso);
  assign rsp_valid     = (state_q == StResponde);
  assign rsp_resultado = acc_q;
  assign ula_A         = acc_q;
  assign ula_B         = b_q;
  assign ula_seletor   = op_q;

endmodule

// File: tb/tb_ula_sequenciador_deslocamento.sv
// Scoreboard bench for ula_sequenciador_deslocamento with a behavioural ALU on its initiator
// side; expected results and latencies are queued at issue and checked by a separate monitor.
module tb_ula_sequenciador_deslocamento;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_A;
  logic [3:0] req_B;
  logic [2:0] req_op;
  logic [2:0] req_n;
  logic [3:0] ula_A;
  logic [3:0] ula_B;
  logic [2:0] ula_seletor;
  logic [3:0] ula_resultado;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_resultado;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] res;
    int         lat;
    logic [2:0] op;
  } exp_t;

  exp_t exp_q[$];

  ula_sequenciador_deslocamento dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_A        (req_A),
    .req_B        (req_B),
    .req_op       (req_op),
    .req_n        (req_n),
    .ula_A        (ula_A),
    .ula_B        (ula_B),
    .ula_seletor  (ula_seletor),
    .ula_resultado(ula_resultado),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_resultado(rsp_resultado)
  );

  // Behavioural model of the existing combinational ALU.
  always_comb begin
    ula_resultado = 4'b0000;
    case (ula_seletor)
      3'b000: ula_resultado = ula_A & ula_B;
      3'b001: ula_resultado = ula_A | ula_B;
      3'b010: ula_resultado = ~ula_A;
      3'b011: ula_resultado = ~(ula_A & ula_B);
      3'b100: ula_resultado = ula_A + ula_B;
      3'b101: ula_resultado = ula_A - ula_B;
      3'b110: ula_resultado = {ula_A[2:0], 1'b0};
      default: ula_resultado = {1'b0, ula_A[3:1]};
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required end");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, required %b at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: cnt counts falling edges since the request was seen accepted.
  int cnt = 0;
  bit seen = 0;
  always @(negedge clk) begin
    if (rst) begin
      cnt  = 0;
      seen = 0;
    end else begin
      cnt++;
      if (req_valid && req_ready) cnt = 0;
      if (!req_ready && !rsp_valid && exp_q.size() != 0) begin
        chk("seletor_in_executa", {1'b0, ula_seletor}, {1'b0, exp_q[0].op});
      end
      if (rsp_valid && !seen) begin
        seen = 1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_response: got rsp_valid=1 with %b, required no response",
                   rsp_resultado);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_resultado", rsp_resultado, e.res);
          checks++;
          if (cnt != e.lat + 1) begin
            errors++;
            $display("FAIL latency: got %0d cycles, required %0d", cnt - 1, e.lat);
          end
        end
      end
      if (rsp_valid && rsp_ready) seen = 0;
    end
  end

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                      input logic [2:0] n, input logic [3:0] res, input bit push);
    exp_t e;
    e.res = res;
    e.op  = op;
    if (op[2:1] == 2'b11) e.lat = int'(n);
    else e.lat = 1;
    if (push) exp_q.push_back(e);
    req_A     = a;
    req_B     = b;
    req_op    = op;
    req_n     = n;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (req_ready && exp_q.size() == 0) done = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got busy after 40 cycles, required idle");
    end
  endtask

  initial begin
    logic [3:0] held;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_A     = 4'b0000;
    req_B     = 4'b0000;
    req_op    = 3'b000;
    req_n     = 3'b000;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", {3'b0, req_ready}, 4'b0001);
    chk("reset_rsp_valid", {3'b0, rsp_valid}, 4'b0000);
    chk("reset_ula_A", ula_A, 4'b0000);
    chk("reset_ula_B", ula_B, 4'b0000);
    chk("reset_seletor", {1'b0, ula_seletor}, 4'b0000);
    chk("reset_rsp_resultado", rsp_resultado, 4'b0000);
    rst = 1'b0;
    @(posedge clk);
    #1;

    send(4'b0101, 4'b0011, 3'b100, 3'd0, 4'b1000, 1); wait_idle();
    send(4'b0101, 4'b0011, 3'b011, 3'd0, 4'b1110, 1); wait_idle();
    send(4'b1101, 4'b1010, 3'b101, 3'd5, 4'b0011, 1); wait_idle();
    send(4'b1101, 4'b1010, 3'b010, 3'd0, 4'b0010, 1); wait_idle();
    send(4'b1001, 4'b0000, 3'b110, 3'd1, 4'b0010, 1); wait_idle();
    send(4'b1001, 4'b0000, 3'b110, 3'd2, 4'b0100, 1); wait_idle();
    send(4'b1001, 4'b0000, 3'b111, 3'd3, 4'b0001, 1); wait_idle();
    send(4'b1011, 4'b0000, 3'b110, 3'd0, 4'b1011, 1); wait_idle();
    send(4'b1111, 4'b0000, 3'b111, 3'd6, 4'b0000, 1); wait_idle();

    // Backpressure: response must hold while rsp_ready is low.
    rsp_ready = 1'b0;
    send(4'b1010, 4'b0101, 3'b001, 3'd0, 4'b1111, 1);
    for (int i = 0; i < 10 && !rsp_valid; i++) begin
      @(posedge clk);
      #1;
    end
    chk("bp_rsp_valid_rise", {3'b0, rsp_valid}, 4'b0001);
    held = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_rsp_valid", {3'b0, rsp_valid}, 4'b0001);
      chk("bp_rsp_resultado", rsp_resultado, held);
      chk("bp_req_ready", {3'b0, req_ready}, 4'b0000);
      req_valid = ~req_valid;
      req_A     = req_A + 4'd3;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_req_ready", {3'b0, req_ready}, 4'b0001);
    chk("bp_queue_empty", exp_q.size() == 0 ? 4'b0001 : 4'b0000, 4'b0001);

    // Abort a long shift with an asynchronous reset in the middle of a cycle.
    send(4'b1001, 4'b0000, 3'b110, 3'd7, 4'b0000, 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("abort_req_ready", {3'b0, req_ready}, 4'b0001);
    chk("abort_rsp_valid", {3'b0, rsp_valid}, 4'b0000);
    chk("abort_ula_A", ula_A, 4'b0000);
    chk("abort_ula_B", ula_B, 4'b0000);
    chk("abort_seletor", {1'b0, ula_seletor}, 4'b0000);
    chk("abort_rsp_resultado", rsp_resultado, 4'b0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    chk("abort_no_response", {3'b0, rsp_valid}, 4'b0000);

    send(4'b0111, 4'b0001, 3'b100, 3'd0, 4'b1000, 1); wait_idle();

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
